// File: rtl/maf_final_adder.sv
// Final carry-propagate adder for a multiply-add datapath: resolves the CSA tree's
// redundant sum/carry pair into a WIDTH-bit product plus overflow bit over two stages.
module maf_final_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_out,
    output logic             cout_out
);

    localparam int HALF = WIDTH / 2;

    logic            r_s1_valid;
    logic [HALF-1:0] r_s1_lo_sum;
    logic            r_s1_lo_cout;
    logic [HALF-1:0] r_s1_sum_hi;
    logic [HALF:0]   r_s1_carry_hi;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_prod;
    logic             r_cout;

    logic          w_accept;
    logic          w_s1_advance;
    logic          w_out_fire;
    logic [HALF:0] w_lo_add;
    logic [HALF:0] w_hi_add;

    // Carry vector is unshifted, so its bit HALF-1 lands at weight 2^HALF and
    // seeds the high half; its MSB lands at weight 2^WIDTH and feeds cout.
    assign w_lo_add = {1'b0, sum_in[HALF-1:0]} + {1'b0, carry_in[HALF-2:0], 1'b0};
    assign w_hi_add = {1'b0, r_s1_sum_hi} + r_s1_carry_hi + {{HALF{1'b0}}, r_s1_lo_cout};

    assign w_out_fire   = r_s2_valid && out_ready;
    assign w_s1_advance = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready     = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_accept     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_lo_sum   <= '0;
            r_s1_lo_cout  <= 1'b0;
            r_s1_sum_hi   <= '0;
            r_s1_carry_hi <= '0;
        end else if (w_accept) begin
            r_s1_valid    <= 1'b1;
            r_s1_lo_sum   <= w_lo_add[HALF-1:0];
            r_s1_lo_cout  <= w_lo_add[HALF];
            r_s1_sum_hi   <= sum_in[WIDTH-1:HALF];
            r_s1_carry_hi <= carry_in[WIDTH-1:HALF-1];
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Data registers hold across stalls, which keeps the output stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_prod     <= '0;
            r_cout     <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= 1'b1;
            r_prod     <= {w_hi_add[HALF-1:0], r_s1_lo_sum};
            r_cout     <= w_hi_add[HALF];
        end else if (w_out_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign prod_out  = r_prod;
    assign cout_out  = r_cout;

endmodule
